// File: rtl/ga25_sdram_arb.sv
// N-channel read arbiter: edge-triggered client requests share one SDRAM read port,
// one outstanding read at a time, with fixed-priority or round-robin selection.
module ga25_sdram_arb #(
    parameter int                    NUM_CH      = 3,
    parameter int                    ADDR_W      = 22,
    parameter int                    DATA_W      = 32,
    parameter int                    SDR_ADDR_W  = 25,
    parameter logic [SDR_ADDR_W-1:0] BASE_ADDR   = '0,
    parameter bit                    ROUND_ROBIN = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH*ADDR_W-1:0]   addr,
    input  logic [NUM_CH-1:0]          req,
    output logic [NUM_CH*DATA_W-1:0]   data,
    output logic [NUM_CH-1:0]          rdy,
    output logic [NUM_CH-1:0]          pending,
    output logic [SDR_ADDR_W-1:0]      sdr_addr,
    output logic                       sdr_req,
    input  logic [DATA_W-1:0]          sdr_data,
    input  logic                       sdr_rdy
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [NUM_CH-1:0]       req_d;
    logic [NUM_CH-1:0]       new_edge;
    logic [NUM_CH-1:0]       grant_mask;
    logic [SDR_ADDR_W-1:0]   lat_addr [NUM_CH];
    logic [IDX_W-1:0]        active;
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        ptr_next;
    logic [IDX_W-1:0]        win;
    logic                    win_valid;
    logic                    grant;
    logic                    complete;

    // An edge on an already-pending channel is dropped so the first address wins.
    assign new_edge = req & ~req_d & ~pending;

    // Scan from ptr (round-robin) or from 0 (fixed priority); first pending wins.
    always_comb begin
        int idx;
        idx       = 0;
        win       = '0;
        win_valid = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            idx = ROUND_ROBIN ? ((int'(ptr) + j) % NUM_CH) : j;
            if (!win_valid && pending[idx]) begin
                win_valid = 1'b1;
                win       = idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    grant      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (sdr_rdy) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant_mask = grant ? (NUM_CH'(1) << win) : '0;
    assign ptr_next   = (win == IDX_W'(NUM_CH - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_d    <= '0;
            pending  <= '0;
            data     <= '0;
            rdy      <= '0;
            sdr_addr <= '0;
            sdr_req  <= 1'b0;
            active   <= '0;
            ptr      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                lat_addr[i] <= '0;
            end
        end else begin
            req_d   <= req;
            rdy     <= '0;
            sdr_req <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (new_edge[i]) begin
                    lat_addr[i] <= BASE_ADDR | SDR_ADDR_W'(addr[i*ADDR_W +: ADDR_W]);
                end
            end
            // new_edge never targets the granted channel, so set and clear cannot collide.
            pending <= (pending & ~grant_mask) | new_edge;
            if (grant) begin
                sdr_req  <= 1'b1;
                sdr_addr <= lat_addr[win];
                active   <= win;
                if (ROUND_ROBIN) begin
                    ptr <= ptr_next;
                end
            end
            if (complete) begin
                data[int'(active)*DATA_W +: DATA_W] <= sdr_data;
                rdy[active]                         <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ga25_sdram_arb.sv
// Bench for ga25_sdram_arb: a fixed-priority and a round-robin instance run side by side
// against a cycle-level reference model, plus directed checks on the key scenarios.
module tb_ga25_sdram_arb;

    localparam int NUM_CH     = 3;
    localparam int ADDR_W     = 22;
    localparam int DATA_W     = 32;
    localparam int SDR_ADDR_W = 25;
    localparam logic [SDR_ADDR_W-1:0] BASE = 25'h0800000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       reset;
    logic [NUM_CH*ADDR_W-1:0]   addr;
    logic [NUM_CH-1:0]          req;
    logic                       s_rdy  [2];
    logic [DATA_W-1:0]          s_data [2];
    logic [NUM_CH*DATA_W-1:0]   o_data [2];
    logic [NUM_CH-1:0]          o_rdy  [2];
    logic [NUM_CH-1:0]          o_pend [2];
    logic [SDR_ADDR_W-1:0]      o_saddr[2];
    logic                       o_sreq [2];

    ga25_sdram_arb #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SDR_ADDR_W(SDR_ADDR_W),
        .BASE_ADDR(BASE), .ROUND_ROBIN(1'b0)
    ) dut_fp (
        .clk(clk), .reset(reset), .addr(addr), .req(req),
        .data(o_data[0]), .rdy(o_rdy[0]), .pending(o_pend[0]),
        .sdr_addr(o_saddr[0]), .sdr_req(o_sreq[0]),
        .sdr_data(s_data[0]), .sdr_rdy(s_rdy[0])
    );

    ga25_sdram_arb #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SDR_ADDR_W(SDR_ADDR_W),
        .BASE_ADDR(BASE), .ROUND_ROBIN(1'b1)
    ) dut_rr (
        .clk(clk), .reset(reset), .addr(addr), .req(req),
        .data(o_data[1]), .rdy(o_rdy[1]), .pending(o_pend[1]),
        .sdr_addr(o_saddr[1]), .sdr_req(o_sreq[1]),
        .sdr_data(s_data[1]), .sdr_rdy(s_rdy[1])
    );

    // Reference model, index 0 = fixed priority, 1 = round robin.
    bit [NUM_CH-1:0]         m_pend  [2];
    logic [SDR_ADDR_W-1:0]   m_laddr [2][NUM_CH];
    bit                      m_busy  [2];
    int                      m_act   [2];
    int                      m_ptr   [2];
    bit [NUM_CH-1:0]         m_reqd;
    logic [DATA_W-1:0]       m_data  [2][NUM_CH];
    bit [NUM_CH-1:0]         m_rdy   [2];
    bit                      m_sreq  [2];
    logic [SDR_ADDR_W-1:0]   m_saddr [2];
    bit [NUM_CH-1:0]         m_edges;
    int                      m_w;

    function automatic int pick(bit [NUM_CH-1:0] p, int start);
        for (int k = 0; k < NUM_CH; k++) begin
            if (p[(start + k) % NUM_CH]) return (start + k) % NUM_CH;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_reqd = '0;
            for (int c = 0; c < 2; c++) begin
                m_pend[c] = '0; m_busy[c] = 1'b0; m_act[c] = 0; m_ptr[c] = 0;
                m_rdy[c] = '0; m_sreq[c] = 1'b0; m_saddr[c] = '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    m_data[c][i] = '0; m_laddr[c][i] = '0;
                end
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                m_edges   = req & ~m_reqd & ~m_pend[c];
                m_rdy[c]  = '0;
                m_sreq[c] = 1'b0;
                if (!m_busy[c]) begin
                    if (m_pend[c] != '0) begin
                        m_w           = pick(m_pend[c], (c == 1) ? m_ptr[c] : 0);
                        m_sreq[c]     = 1'b1;
                        m_saddr[c]    = m_laddr[c][m_w];
                        m_act[c]      = m_w;
                        m_busy[c]     = 1'b1;
                        m_pend[c][m_w] = 1'b0;
                        if (c == 1) m_ptr[c] = (m_w + 1) % NUM_CH;
                    end
                end else if (s_rdy[c]) begin
                    m_data[c][m_act[c]] = s_data[c];
                    m_rdy[c][m_act[c]]  = 1'b1;
                    m_busy[c]           = 1'b0;
                end
                for (int i = 0; i < NUM_CH; i++) begin
                    if (m_edges[i]) begin
                        m_pend[c][i]  = 1'b1;
                        m_laddr[c][i] = BASE | SDR_ADDR_W'(addr[i*ADDR_W +: ADDR_W]);
                    end
                end
            end
            m_reqd = req;
        end
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [NUM_CH*DATA_W-1:0] exp_d;
        string nm;
        for (int c = 0; c < 2; c++) begin
            nm = (c == 0) ? "fp" : "rr";
            for (int i = 0; i < NUM_CH; i++) exp_d[i*DATA_W +: DATA_W] = m_data[c][i];
            chk({nm, "_data"},     128'(o_data[c]),  128'(exp_d));
            chk({nm, "_rdy"},      128'(o_rdy[c]),   128'(m_rdy[c]));
            chk({nm, "_pending"},  128'(o_pend[c]),  128'(m_pend[c]));
            chk({nm, "_sdr_req"},  128'(o_sreq[c]),  128'(m_sreq[c]));
            chk({nm, "_sdr_addr"}, 128'(o_saddr[c]), 128'(m_saddr[c]));
        end
    endtask

    bit auto_resp = 1'b0;
    int lat_lo = 1;
    int lat_hi = 6;
    int resp_cnt [2] = '{0, 0};

    // One clock: check at the falling edge, then drive the SDRAM side for the next edge.
    task automatic step();
        @(negedge clk);
        check_all();
        for (int c = 0; c < 2; c++) begin
            s_rdy[c] = 1'b0;
            if (auto_resp) begin
                if (reset) begin
                    resp_cnt[c] = 0;
                end else if (m_sreq[c]) begin
                    resp_cnt[c] = $urandom_range(lat_hi, lat_lo);
                end else if (resp_cnt[c] > 0) begin
                    resp_cnt[c]--;
                    if (resp_cnt[c] == 0) begin
                        s_rdy[c]  = 1'b1;
                        s_data[c] = $urandom;
                    end
                end
            end
        end
    endtask

    task automatic pulse_rdy(input logic [DATA_W-1:0] d);
        s_rdy[0] = 1'b1; s_rdy[1] = 1'b1;
        s_data[0] = d;   s_data[1] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; auto_resp = 1'b0;
        resp_cnt[0] = 0; resp_cnt[1] = 0;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    function automatic int onehot_idx(logic [NUM_CH-1:0] v);
        for (int i = 0; i < NUM_CH; i++) if (v[i]) return i;
        return -1;
    endfunction

    int order [4];
    int n_ord;
    int n_sreq;
    int rdy_cnt [NUM_CH];
    int exp_order [4];

    initial begin
        reset = 1'b1; req = '0; addr = '0;
        s_rdy[0] = 1'b0; s_rdy[1] = 1'b0; s_data[0] = '0; s_data[1] = '0;
        do_reset();
        chk("reset_pending", 128'(o_pend[0]), 128'(0));

        // Single read on channel 0 through the region base.
        addr[0 +: ADDR_W] = 22'h001234;
        req = 3'b001; step();
        req = 3'b000; step();
        chk("t1_sdr_req", 128'(o_sreq[0]), 128'(1));
        chk("t1_sdr_addr", 128'(o_saddr[0]), 128'(25'h0801234));
        step(); step();
        pulse_rdy(32'hDEADBEEF); step();
        chk("t1_rdy", 128'(o_rdy[0]), 128'(3'b001));
        chk("t1_data", 128'(o_data[0][31:0]), 128'(32'hDEADBEEF));
        step();

        // All three channels at once, fixed latency 4.
        do_reset();
        auto_resp = 1'b1; lat_lo = 4; lat_hi = 4;
        addr = 66'({$urandom(), $urandom(), $urandom()});
        req = 3'b111; step();
        req = 3'b000;
        n_ord = 0; n_sreq = 0;
        for (int i = 0; i < NUM_CH; i++) rdy_cnt[i] = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (o_sreq[0]) n_sreq++;
            for (int i = 0; i < NUM_CH; i++) if (o_rdy[0][i]) rdy_cnt[i]++;
            if (o_rdy[0] != '0 && n_ord < 4) begin order[n_ord] = onehot_idx(o_rdy[0]); n_ord++; end
        end
        chk("t2_sreq_count", 128'(n_sreq), 128'(3));
        for (int i = 0; i < NUM_CH; i++) chk("t2_rdy_count", 128'(rdy_cnt[i]), 128'(1));
        exp_order = '{0, 1, 2, 0};
        for (int i = 0; i < 3; i++) chk("t2_order", 128'(order[i]), 128'(exp_order[i]));

        // Channel 0 re-requests after each completion; round robin must rotate.
        do_reset();
        auto_resp = 1'b1; lat_lo = 2; lat_hi = 2;
        addr = 66'({$urandom(), $urandom(), $urandom()});
        req = 3'b111; step();
        req = 3'b000;
        n_ord = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (o_rdy[1] != '0 && n_ord < 4) begin order[n_ord] = onehot_idx(o_rdy[1]); n_ord++; end
            req = {2'b00, m_rdy[1][0]};
        end
        req = 3'b000;
        chk("t3_served", 128'(n_ord), 128'(4));
        for (int i = 0; i < 4; i++) chk("t3_rr_order", 128'(order[i]), 128'(exp_order[i]));
        repeat (40) step();

        // Second edge on a pending channel is dropped; first address wins.
        do_reset();
        addr[0 +: ADDR_W] = 22'h000111;
        req = 3'b001; step();
        req = 3'b000; step();
        addr[ADDR_W +: ADDR_W] = 22'h2ABCDE;
        req = 3'b010; step();
        req = 3'b000; step();
        addr[ADDR_W +: ADDR_W] = 22'h155555;
        req = 3'b010; step();
        chk("t4_pending", 128'(o_pend[0]), 128'(3'b010));
        req = 3'b000; step();
        pulse_rdy($urandom); step();
        step();
        chk("t4_sdr_req", 128'(o_sreq[0]), 128'(1));
        chk("t4_first_addr", 128'(o_saddr[0]), 128'(BASE | 25'h2ABCDE));
        step();
        pulse_rdy(32'h0BADF00D); step();
        chk("t4_rdy", 128'(o_rdy[0]), 128'(3'b010));
        repeat (4) begin
            step();
            chk("t4_no_reissue", 128'(o_sreq[0]), 128'(0));
        end

        // Reset while busy discards the read; a stray completion is ignored.
        do_reset();
        req = 3'b001; step();
        req = 3'b000; step();
        step();
        reset = 1'b1; step();
        reset = 1'b0; step();
        pulse_rdy(32'h12345678); step();
        chk("t5_rdy", 128'(o_rdy[0]), 128'(0));
        chk("t5_data", 128'(o_data[0]), 128'(0));
        chk("t5_pending", 128'(o_pend[0]), 128'(0));
        req = 3'b010; step();
        req = 3'b000; step();
        chk("t5_next_sreq", 128'(o_sreq[0]), 128'(1));
        step();
        pulse_rdy(32'hCAFE0001); step();
        chk("t5_next_rdy", 128'(o_rdy[0]), 128'(3'b010));

        // Completion while idle with nothing pending.
        repeat (2) step();
        pulse_rdy(32'hFFFFFFFF); step();
        chk("t6_idle_rdy", 128'(o_rdy[0]), 128'(0));
        step();

        // Randomized traffic with variable SDRAM latency.
        auto_resp = 1'b1; lat_lo = 1; lat_hi = 6;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(1, 0) == 1) req = NUM_CH'($urandom_range(7, 0));
            addr = 66'({$urandom(), $urandom(), $urandom()});
            step();
        end
        req = 3'b000;
        repeat (40) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
